// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request type for the register-file
// writeback controller and its arbiter.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant, the pointer moves only
// when a grant is issued. Grants are suppressed while rst is high.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 0: requester 0 wins the next tie, 1: requester 1 wins it
    logic r_ptr;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        o_gnt = 2'b00;
        if (!rst) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|o_gnt) begin
            r_ptr <= o_gnt[0];
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates two writeback ports into a single
// register-file write and keeps a busy scoreboard for hazard checks.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wb0_valid,
    output logic                           wb0_ready,
    input  logic [regfile_pkg::REG_AW-1:0] wb0_rd,
    input  logic [XLEN-1:0]                wb0_data,
    input  logic                           wb1_valid,
    output logic                           wb1_ready,
    input  logic [regfile_pkg::REG_AW-1:0] wb1_rd,
    input  logic [XLEN-1:0]                wb1_data,
    input  logic                           alloc_valid,
    input  logic [regfile_pkg::REG_AW-1:0] alloc_rd,
    output logic                           alloc_ready,
    input  logic [regfile_pkg::REG_AW-1:0] rs1,
    input  logic [regfile_pkg::REG_AW-1:0] rs2,
    output logic                           busy_rs1,
    output logic                           busy_rs2,
    output logic                           rf_we,
    output logic [regfile_pkg::REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]                rf_wdata
);

    localparam int NSLOT = 1 << REG_AW;

    logic [1:0]        w_gnt;
    logic              w_wb_fire;
    logic              w_alloc_fire;
    wb_req_t           w_req;
    logic [NREG-1:0]   r_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic [NSLOT-1:0]  w_busy_full;
    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req ({wb1_valid, wb0_valid}),
        .o_gnt (w_gnt)
    );

    assign wb0_ready = w_gnt[0];
    assign wb1_ready = w_gnt[1];
    assign w_wb_fire = |w_gnt;

    always_comb begin
        w_req = '{rd: wb0_rd, data: wb0_data};
        if (w_gnt[1]) begin
            w_req = '{rd: wb1_rd, data: wb1_data};
        end
    end

    // Zero-extended view so any 5-bit address indexes safely when NREG < 32
    assign w_busy_full = NSLOT'(r_busy);

    assign alloc_ready  = !rst && ((alloc_rd == '0) || !w_busy_full[alloc_rd]);
    assign w_alloc_fire = alloc_valid && alloc_ready && (alloc_rd != '0);
    assign busy_rs1     = w_busy_full[rs1];
    assign busy_rs2     = w_busy_full[rs2];

    // Clear first, then set, so an allocation wins over a same-cycle writeback
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_wb_fire && (w_req.rd == REG_AW'(i))) w_busy_nxt[i] = 1'b0;
            if (w_alloc_fire && (alloc_rd == REG_AW'(i))) w_busy_nxt[i] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: the scoreboard is flops, not a RAM, so it is fully cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_we   <= w_wb_fire && (w_req.rd != '0);
            if (w_wb_fire) begin
                r_waddr <= w_req.rd;
                r_wdata <= w_req.data;
            end
        end
    end

    assign rf_we    = r_we;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and random stimulus for regfile_wb_ctrl, checked against a
// cycle-level reference model of arbitration, writeback and scoreboard.
module tb_regfile_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        wb0_valid, wb1_valid;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd, wb1_rd;
    logic [31:0] wb0_data, wb1_data;
    logic        alloc_valid, alloc_ready;
    logic [4:0]  alloc_rd;
    logic [4:0]  rs1, rs2;
    logic        busy_rs1, busy_rs2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_wb_ctrl #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb0_valid  (wb0_valid),
        .wb0_ready  (wb0_ready),
        .wb0_rd     (wb0_rd),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_ready  (wb1_ready),
        .wb1_rd     (wb1_rd),
        .wb1_data   (wb1_data),
        .alloc_valid(alloc_valid),
        .alloc_rd   (alloc_rd),
        .alloc_ready(alloc_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy_rs1   (busy_rs1),
        .busy_rs2   (busy_rs2),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending-write set, last winner, last register-file write
    bit          mdl_busy [32];
    int          mdl_last;
    logic        mdl_we;
    logic [4:0]  mdl_waddr;
    logic [31:0] mdl_wdata;

    // Handshake values seen just before the most recent edge
    logic obs_r0, obs_r1, obs_ar;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
        mdl_last  = 1;
        mdl_we    = 1'b0;
        mdl_waddr = '0;
        mdl_wdata = '0;
    endtask

    // One clock: drive at negedge, check handshakes before the edge and
    // the registered outputs just after it.
    task automatic step(input logic r,
                        input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                        input logic av, input logic [4:0] ard,
                        input logic [4:0] s1, input logic [4:0] s2);
        int          win;
        logic        e_ar;
        logic [4:0]  g_rd;
        logic [31:0] g_data;
        @(negedge clk);
        rst = r;
        wb0_valid = v0; wb0_rd = rd0; wb0_data = d0;
        wb1_valid = v1; wb1_rd = rd1; wb1_data = d1;
        alloc_valid = av; alloc_rd = ard;
        rs1 = s1; rs2 = s2;
        #1;
        win = -1;
        if (!r) begin
            if (v0 && v1)  win = (mdl_last == 0) ? 1 : 0;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        e_ar = !r && (ard == 5'd0 || !mdl_busy[ard]);
        chk("wb0_ready", {31'b0, wb0_ready}, {31'b0, win == 0});
        chk("wb1_ready", {31'b0, wb1_ready}, {31'b0, win == 1});
        chk("alloc_ready", {31'b0, alloc_ready}, {31'b0, e_ar});
        chk("busy_rs1_pre", {31'b0, busy_rs1}, {31'b0, mdl_busy[s1]});
        chk("busy_rs2_pre", {31'b0, busy_rs2}, {31'b0, mdl_busy[s2]});
        obs_r0 = wb0_ready; obs_r1 = wb1_ready; obs_ar = alloc_ready;
        @(posedge clk);
        #1;
        if (r) begin
            mdl_reset();
        end else begin
            mdl_we = 1'b0;
            if (win >= 0) begin
                g_rd   = (win == 0) ? rd0 : rd1;
                g_data = (win == 0) ? d0 : d1;
                mdl_last  = win;
                mdl_waddr = g_rd;
                mdl_wdata = g_data;
                if (g_rd != 5'd0) begin
                    mdl_we = 1'b1;
                    mdl_busy[g_rd] = 1'b0;
                end
            end
            if (av && e_ar && ard != 5'd0) mdl_busy[ard] = 1'b1;
        end
        chk("rf_we", {31'b0, rf_we}, {31'b0, mdl_we});
        chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, mdl_waddr});
        chk("rf_wdata", rf_wdata, mdl_wdata);
        chk("busy_rs1_post", {31'b0, busy_rs1}, {31'b0, mdl_busy[s1]});
        chk("busy_rs2_post", {31'b0, busy_rs2}, {31'b0, mdl_busy[s2]});
    endtask

    task automatic idle(input logic r, input logic [4:0] s1, input logic [4:0] s2);
        step(r, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, s1, s2);
    endtask

    initial begin
        rst = 1'b1;
        wb0_valid = 0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 0; wb1_rd = '0; wb1_data = '0;
        alloc_valid = 0; alloc_rd = '0; rs1 = '0; rs2 = '0;
        mdl_reset();

        // Reset state
        idle(1, 5'd0, 5'd1);
        idle(1, 5'd3, 5'd31);
        chk("reset_rf_we", {31'b0, rf_we}, 32'd0);
        chk("reset_rf_wdata", rf_wdata, 32'd0);

        // Single wb0 writeback with 1-cycle latency
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd5, 5'd0);
        chk("wb0_ready_single", {31'b0, obs_r0}, 32'd1);
        chk("single_we", {31'b0, rf_we}, 32'd1);
        chk("single_waddr", {27'b0, rf_waddr}, 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        idle(0, 5'd5, 5'd0);
        chk("no_grant_we", {31'b0, rf_we}, 32'd0);
        chk("hold_wdata", rf_wdata, 32'hDEADBEEF);

        // Both ports valid after reset: grants alternate 0,1,0,1
        idle(1, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 5'(10 + i), 32'(100 + i), 1, 5'(20 + i), 32'(200 + i),
                 0, 5'd0, 5'd0, 5'd0);
            chk("tie_gnt0", {31'b0, obs_r0}, {31'b0, (i % 2) == 0});
            chk("tie_gnt1", {31'b0, obs_r1}, {31'b0, (i % 2) == 1});
            chk("tie_waddr", {27'b0, rf_waddr}, (i % 2 == 0) ? 32'(10 + i) : 32'(20 + i));
        end

        // Allocate r7, WAW stall, then clear via wb1
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
        chk("alloc7_ready", {31'b0, obs_ar}, 32'd1);
        chk("alloc7_busy", {31'b0, busy_rs1}, 32'd1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd0);
        chk("alloc7_waw", {31'b0, obs_ar}, 32'd0);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h7777, 0, 5'd0, 5'd7, 5'd0);
        chk("wb1_clear7", {31'b0, busy_rs1}, 32'd0);

        // Same-cycle allocate and writeback to r9: set wins
        step(0, 1, 5'd9, 32'h99, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
        chk("setprio_busy9", {31'b0, busy_rs1}, 32'd1);
        chk("setprio_we", {31'b0, rf_we}, 32'd1);
        chk("setprio_waddr", {27'b0, rf_waddr}, 32'd9);

        // Writeback to r0: handshake but no write
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1234, 0, 5'd0, 5'd0, 5'd9);
        chk("rd0_ready", {31'b0, obs_r1}, 32'd1);
        chk("rd0_we", {31'b0, rf_we}, 32'd0);
        chk("rd0_busy", {31'b0, busy_rs1}, 32'd0);

        // Reset with a pending register and a request in flight
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd3, 5'd9);
        step(1, 1, 5'd3, 32'h3333, 0, 5'd0, 32'd0, 1, 5'd4, 5'd3, 5'd9);
        chk("rst_ready0", {31'b0, obs_r0}, 32'd0);
        chk("rst_alloc_ready", {31'b0, obs_ar}, 32'd0);
        chk("rst_busy3", {31'b0, busy_rs1}, 32'd0);
        chk("rst_we", {31'b0, rf_we}, 32'd0);

        // Random traffic on a narrow register range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom), 5'($urandom_range(0, 11)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 11)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 11)),
                 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
